mix_w_ctrl: RTL and testbench
=============================

# mix_w_ctrl

Sequencer for the mix-layer weight RAM (three stacked HID_DIM×HID_DIM matrices W1/W2/W3, each MAT_DEPTH words of DATA_N packed weights, 1-cycle synchronous read). The block streams one selected matrix to the mix datapath in forward mode. In update mode it performs a read-old / write-new sweep with the optimizer. It is the only agent driving the RAM's raddr/load/waddr/wdata ports.

## Interface
- ADDR_WIDTH, 9: RAM address width.
- DATA_WIDTH, `DATA_N*`N_LEN_W: RAM word width.
- MAT_DEPTH, `HID_DIM*`HID_DIM/`DATA_N: words per matrix; base of matrix m = m*MAT_DEPTH.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start pulse, sampled only in IDLE.
- mode  in  1  0 = forward read, 1 = update; sampled with run.
- mat_sel  in  2  matrix 0..2; sampled with run.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse on sweep completion.
- err  out  1  one-cycle pulse when run arrives with mat_sel==3.
- ram_raddr  out  ADDR_WIDTH  read address.
- ram_rdata  in  DATA_WIDTH  read data, valid one cycle after the address.
- ram_load  out  1  write enable.
- ram_waddr  out  ADDR_WIDTH  write address.
- ram_wdata  out  DATA_WIDTH  write data.
- w_data  out  DATA_WIDTH  weight word to the datapath or optimizer (old value in update mode).
- w_valid  out  1  w_data valid.
- w_ready  in  1  consumer accepts on w_valid&&w_ready.
- upd_data  in  DATA_WIDTH  new weight word from the optimizer.
- upd_valid  in  1  upd_data valid.
- upd_ready  out  1  block accepts on upd_valid&&upd_ready.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, run=1, mat_sel<3: latch mode and base, clear counters, go to RUN.
- IDLE, run=1, mat_sel==3: pulse err next cycle and stay in IDLE.
- run is ignored outside IDLE.
- Counters: rd_cnt (reads issued), dl_cnt (words handed out on w_*), wr_cnt (updates written). Each counter is 0..MAT_DEPTH wide.
- Read issue:
  - Issue in RUN when rd_cnt<MAT_DEPTH and fifo_cnt + inflight − pop < 3.
  - ram_raddr = base + rd_cnt.
  - inflight is a 1-bit flag for the read issued last cycle.
  - Returning data is pushed into a 3-entry output FIFO; w_data/w_valid come from the FIFO head.
- Read timing: ram_raddr is registered and the read strobe advances rd_cnt. Data returns in the cycle after the address is presented.
- Update mode:
  - upd_ready = RUN && mode && wr_cnt<dl_cnt, so only already-delivered words can be written back.
  - On accept: ram_load=1, ram_waddr = base + wr_cnt, ram_wdata = upd_data, wr_cnt++.
  - ram_load, ram_waddr and ram_wdata are registered, so the write occurs the cycle after accept.
  - Reads always lead writes, so no read-during-write collision on the same address can occur.
- Forward mode: upd_ready=0 and ram_load is never asserted.
- Completion:
  - Forward: completes when dl_cnt==MAT_DEPTH.
  - Update: completes when wr_cnt==MAT_DEPTH and the last write has been issued.
  - On completion, enter DONE: done=1 for one cycle, then IDLE.
- Counter arithmetic is unsigned. base + count never exceeds 3*MAT_DEPTH−1.

## Timing
- Reset values: busy=0, done=0, err=0, ram_load=0, ram_raddr=0, ram_waddr=0, ram_wdata=0, w_valid=0, upd_ready=0. FIFO, counters and inflight are cleared.
- rst in any state returns to IDLE next cycle and discards the FIFO. No ram_load is asserted in the cycle after rst.
- Cycle 0 run: ram_raddr=base in cycle 1. Data is in the FIFO at the end of cycle 2. w_valid=1 in cycle 3.
- With w_ready held high, one word per cycle is delivered.
- Forward sweep: done rises at cycle MAT_DEPTH+3 (with w_ready=1).
- w_ready low: the FIFO fills to 3 and issue stops. No word is lost or duplicated. w_data is held stable while w_valid && !w_ready.
- An update accepted in cycle t produces ram_load in cycle t+1.
- Simultaneous FIFO push and pop: fifo_cnt is unchanged.

## Test plan
- MAT_DEPTH=8, forward, mat_sel=1, w_ready=1:
  - ram_raddr = 8..15 on consecutive cycles.
  - 8 words delivered in order, w_valid first high at cycle 3.
  - done pulses once; ram_load never asserts.
- Forward with w_ready toggling 1,0,0,1 repeatedly:
  - Word order and count stay exact.
  - FIFO never exceeds 3 entries; w_data is stable during stalls.
- Update, mat_sel=2, optimizer returns old+1 with 0–3 cycle random delay:
  - RAM addresses 16..23 end up holding old+1.
  - upd_ready stays low whenever wr_cnt==dl_cnt.
- run with mat_sel=3: one err pulse, busy stays 0, no RAM activity.
- rst asserted mid-update after 3 writes:
  - IDLE next cycle; addresses from base+3 onward are unchanged.
  - A following forward run starts cleanly from base.
- run asserted during RUN: ignored, sweep unaffected, exactly one done pulse.

Source files
------------

// File: rtl/mix_w_ctrl.sv
// mix_w_ctrl
// Sequencer for the mix-layer weight RAM. Three matrices of MAT_DEPTH words
// are stacked in the RAM; matrix m starts at address m*MAT_DEPTH.
//   forward (mode=0): stream the selected matrix out on w_*.
//   update  (mode=1): stream the old words out on w_*, take the new words
//                     back on upd_* and write them to the same addresses.
// The RAM has a 1-cycle synchronous read. Read data lands in a 3-entry FIFO
// whose head drives w_data/w_valid.
//
// Handshake rule (w_* and upd_*): a word transfers on the rising edge where
// valid and ready are both high. valid never depends combinationally on
// ready, and the producer holds data stable while valid=1 and ready=0.
module mix_w_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int MAT_DEPTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_mode,
  input  logic [1:0]            i_mat_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_ram_raddr,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_ram_load,
  output logic [ADDR_WIDTH-1:0] o_ram_waddr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic [DATA_WIDTH-1:0] o_w_data,
  output logic                  o_w_valid,
  input  logic                  i_w_ready,
  input  logic [DATA_WIDTH-1:0] i_upd_data,
  input  logic                  i_upd_valid,
  output logic                  o_upd_ready,
  output logic [1:0]            o_dbg_state
);

  // Counters run 0..MAT_DEPTH inclusive.
  localparam int CW = $clog2(MAT_DEPTH + 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(MAT_DEPTH);
  localparam logic [CW-1:0]         LAST_C    = CW'(MAT_DEPTH - 1);
  localparam logic [CW-1:0]         ONE_C     = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] MAT1_BASE = ADDR_WIDTH'(MAT_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MAT2_BASE = ADDR_WIDTH'(2 * MAT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Sweep context latched at start.
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_base;

  // Progress counters.
  logic [CW-1:0]         r_rd_cnt;
  logic [CW-1:0]         r_dl_cnt;
  logic [CW-1:0]         r_wr_cnt;

  // Read pipeline: r_addr_v marks an address presented to the RAM this
  // cycle, r_inflight marks read data arriving on i_ram_rdata this cycle.
  logic                  r_addr_v;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_raddr;

  // Registered write port.
  logic                  r_load;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_err;

  // Output FIFO (entries 0..2 used, pointers wrap at 2).
  logic [DATA_WIDTH-1:0] r_fifo [0:3];
  logic [1:0]            r_fifo_wp;
  logic [1:0]            r_fifo_rp;
  logic [1:0]            r_fifo_cnt;

  // Combinational helpers.
  logic                  w_idle;
  logic                  w_running;
  logic                  w_start;
  logic                  w_bad_sel;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_upd_acc;
  logic                  w_fwd_last;
  logic                  w_upd_last;
  logic [ADDR_WIDTH-1:0] w_base_new;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign w_running = (r_state == S_RUN);
  assign w_start   = w_idle && i_run && (i_mat_sel != 2'd3);
  assign w_bad_sel = w_idle && i_run && (i_mat_sel == 2'd3);

  // Base address of the requested matrix.
  always_comb begin
    w_base_new = '0;
    case (i_mat_sel)
      2'd1:    w_base_new = MAT1_BASE;
      2'd2:    w_base_new = MAT2_BASE;
      default: w_base_new = '0;
    endcase
  end

  // FIFO head is only presented while the sweep runs.
  assign o_w_valid = w_running && (r_fifo_cnt != 2'd0);
  assign o_w_data  = r_fifo[r_fifo_rp];
  assign w_pop     = o_w_valid && i_w_ready;
  assign w_push    = r_inflight;

  // Every outstanding read already owns a FIFO slot, so the FIFO can never
  // overflow even when the consumer stalls indefinitely.
  assign w_occ   = {1'b0, r_fifo_cnt} + {2'b00, r_addr_v} + {2'b00, r_inflight};
  assign w_room  = (w_occ - {2'b00, w_pop}) < 3'd3;
  assign w_issue = w_running && (r_rd_cnt < DEPTH_C) && w_room;

  // Only words already handed to the optimizer may come back for writing.
  assign o_upd_ready = w_running && r_mode && (r_wr_cnt < r_dl_cnt);
  assign w_upd_acc   = i_upd_valid && o_upd_ready;

  assign w_fwd_last = !r_mode && w_pop && (r_dl_cnt == LAST_C);
  assign w_upd_last = r_mode && w_upd_acc && (r_wr_cnt == LAST_C);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: run is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_fwd_last || w_upd_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_RUN: begin
        o_busy = 1'b1;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  assign o_dbg_state = r_state;

  // Sweep context and the bad-select error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= 1'b0;
      r_base <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_bad_sel;
      if (w_start) begin
        r_mode <= i_mode;
        r_base <= w_base_new;
      end
    end
  end

  // Read issue: the first read is launched on the start edge so the base
  // address is on the RAM in the first RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_raddr    <= '0;
      r_rd_cnt   <= '0;
      r_addr_v   <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= r_addr_v;
      if (w_start) begin
        r_raddr  <= w_base_new;
        r_rd_cnt <= ONE_C;
        r_addr_v <= 1'b1;
      end else if (w_issue) begin
        r_raddr  <= r_base + ADDR_WIDTH'(r_rd_cnt);
        r_rd_cnt <= r_rd_cnt + ONE_C;
        r_addr_v <= 1'b1;
      end else begin
        r_addr_v <= 1'b0;
      end
    end
  end

  // Output FIFO: push returning read data, pop on consumer accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fifo_wp  <= 2'd0;
      r_fifo_rp  <= 2'd0;
      r_fifo_cnt <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_fifo_wp] <= i_ram_rdata;
        r_fifo_wp         <= ptr_inc(r_fifo_wp);
      end
      if (w_pop) begin
        r_fifo_rp <= ptr_inc(r_fifo_rp);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Delivered / written counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dl_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_start) begin
      r_dl_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_dl_cnt <= r_dl_cnt + ONE_C;
      end
      if (w_upd_acc) begin
        r_wr_cnt <= r_wr_cnt + ONE_C;
      end
    end
  end

  // Registered RAM write port: an accepted update is written one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_load  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_load <= w_upd_acc;
      if (w_upd_acc) begin
        r_waddr <= r_base + ADDR_WIDTH'(r_wr_cnt);
        r_wdata <= i_upd_data;
      end
    end
  end

  assign o_err       = r_err;
  assign o_ram_raddr = r_raddr;
  assign o_ram_load  = r_load;
  assign o_ram_waddr = r_waddr;
  assign o_ram_wdata = r_wdata;

endmodule

// File: tb/tb_mix_w_ctrl.sv
// Bench for mix_w_ctrl: RAM model, optimizer model, scoreboard on w_*.
module tb_mix_w_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          mode;
  logic [1:0]    mat_sel;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          ram_load;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] upd_data;
  logic          upd_valid;
  logic          upd_ready;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] opt_q[$];
  logic [DW-1:0] mem  [0:511];
  logic [DW-1:0] gold [0:511];

  bit init_req = 1'b1;
  bit opt_en   = 1'b0;
  bit allow_wr = 1'b0;
  bit upd_chk  = 1'b0;
  bit upd_fire = 1'b0;
  bit hold_v   = 1'b0;
  logic [DW-1:0] hold_d = '0;
  int n_dl     = 0;
  int n_wr     = 0;
  int opt_sent = 0;
  int opt_max  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mix_w_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAT_DEPTH(MD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_run       (run),
    .i_mode      (mode),
    .i_mat_sel   (mat_sel),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_ram_raddr (ram_raddr),
    .i_ram_rdata (ram_rdata),
    .o_ram_load  (ram_load),
    .o_ram_waddr (ram_waddr),
    .o_ram_wdata (ram_wdata),
    .o_w_data    (w_data),
    .o_w_valid   (w_valid),
    .i_w_ready   (w_ready),
    .i_upd_data  (upd_data),
    .i_upd_valid (upd_valid),
    .o_upd_ready (upd_ready),
    .o_dbg_state (dbg_state)
  );

  // ---------------- RAM model: 1-cycle synchronous read ----------------
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (ram_load) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_v   = 1'b0;
      upd_fire = 1'b0;
    end else begin
      if (!allow_wr) chk("no_ram_load", 32'(ram_load), 32'd0);
      if (hold_v && w_valid) chk("stall_hold", w_data, hold_d);
      if (upd_chk && busy && n_wr == n_dl) chk("upd_ready_gate", 32'(upd_ready), 32'd0);
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h expected=none", w_data);
        end else begin
          chk("w_data", w_data, exp_q.pop_front());
        end
        n_dl++;
        if (opt_en) opt_q.push_back(w_data + 32'd1);
      end
      hold_v   = w_valid && !w_ready;
      hold_d   = w_data;
      upd_fire = upd_valid && upd_ready;
      if (upd_fire) n_wr++;
    end
  end

  // ---------------- optimizer model: old+1 after 0..3 idle cycles ----------------
  initial begin : optimizer
    int dly;
    dly       = 0;
    upd_valid = 1'b0;
    upd_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (upd_fire) upd_valid = 1'b0;
      if (!upd_valid && opt_q.size() > 0 && opt_sent < opt_max) begin
        if (dly == 0) begin
          upd_data  = opt_q.pop_front();
          upd_valid = 1'b1;
          opt_sent++;
          dly = int'($urandom_range(0, 3));
        end else begin
          dly--;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic start(input bit m, input logic [1:0] sel);
    @(posedge clk); #1;
    run = 1'b1; mode = m; mat_sel = sel;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic fwd_run(input int mat, input bit toggle, input bit extra);
    int first_v = -1;
    int done_at = -1;
    int dc      = 0;
    int base    = mat * MD;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int a = 0; a < MD; a++) exp_q.push_back(gold[base + a]);
    w_ready = 1'b1;
    @(posedge clk); #1;
    run = 1'b1; mode = 1'b0; mat_sel = 2'(mat);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      run = extra && (k == 4);
      if (run) begin
        mode = 1'b1; mat_sel = 2'd1;
      end
      w_ready = toggle ? pat[(k - 1) % 4] : 1'b1;
      @(negedge clk);
      if (k == 1) begin
        chk("fwd_first_raddr", 32'(ram_raddr), 32'(base));
        chk("fwd_busy", 32'(busy), 32'd1);
      end
      if (!toggle && k <= MD) chk("fwd_raddr", 32'(ram_raddr), 32'(base + k - 1));
      if (w_valid && first_v < 0) first_v = k;
      if (done) begin
        dc++;
        if (done_at < 0) done_at = k;
      end
    end
    if (!toggle) begin
      chk("fwd_first_valid_cycle", 32'(first_v), 32'd3);
      chk("fwd_done_cycle", 32'(done_at), 32'(MD + 3));
    end
    chk("fwd_done_count", 32'(dc), 32'd1);
    chk("fwd_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("fwd_idle_after", 32'(busy), 32'd0);
  endtask

  task automatic upd_test();
    for (int a = 16; a < 24; a++) exp_q.push_back(gold[a]);
    n_dl = 0; n_wr = 0; opt_sent = 0; opt_max = 1000;
    opt_en = 1'b1; allow_wr = 1'b1; upd_chk = 1'b1; w_ready = 1'b1;
    start(1'b1, 2'd2);
    wait_done(300, "upd_done");
    repeat (3) @(negedge clk);
    opt_en = 1'b0; upd_chk = 1'b0; allow_wr = 1'b0;
    chk("upd_words_written", 32'(n_wr), 32'(MD));
    chk("upd_exp_empty", 32'(exp_q.size()), 32'd0);
    for (int a = 16; a < 24; a++) gold[a] = gold[a] + 32'd1;
    for (int a = 15; a < 25; a++) chk("upd_ram", mem[a], gold[a]);
  endtask

  task automatic err_test();
    int ec = 0;
    start(1'b0, 2'd3);
    mat_sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (err) ec++;
      if (k == 1) chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_raddr_hold", 32'(ram_raddr), 32'd23);
    end
    chk("err_count", 32'(ec), 32'd1);
  endtask

  task automatic rst_test();
    int lc = 0;
    int k  = 0;
    int extra_lc = 0;
    for (int a = 16; a < 24; a++) exp_q.push_back(gold[a]);
    n_dl = 0; n_wr = 0; opt_sent = 0; opt_max = 3;
    opt_en = 1'b1; allow_wr = 1'b1; upd_chk = 1'b1; w_ready = 1'b1;
    start(1'b1, 2'd2);
    while (lc < 3 && k < 200) begin
      @(negedge clk);
      if (ram_load) lc++;
      k++;
    end
    chk("rst_three_writes", 32'(lc), 32'd3);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (ram_load) extra_lc++;
    end
    chk("rst_no_fourth_write", 32'(extra_lc), 32'd0);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(ram_load), 32'd0);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready), 32'd0);
    exp_q.delete();
    opt_q.delete();
    opt_en = 1'b0; upd_chk = 1'b0; allow_wr = 1'b0;
    for (int a = 16; a < 19; a++) gold[a] = gold[a] + 32'd1;
    for (int a = 16; a < 24; a++) chk("rst_ram", mem[a], gold[a]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; run = 1'b0; mode = 1'b0; mat_sel = 2'd0; w_ready = 1'b0;
    for (int a = 0; a < 512; a++) gold[a] = 32'hA500_0000 | 32'(a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_load", 32'(ram_load), 32'd0);
    chk("reset_raddr", 32'(ram_raddr), 32'd0);
    chk("reset_waddr", 32'(ram_waddr), 32'd0);
    chk("reset_wdata", ram_wdata, 32'd0);
    chk("reset_w_valid", 32'(w_valid), 32'd0);
    chk("reset_upd_ready", 32'(upd_ready), 32'd0);
    @(posedge clk); #1;
    init_req = 1'b0;
    rst = 1'b0;

    fwd_run(1, 1'b0, 1'b0);   // timing, addresses 8..15
    fwd_run(0, 1'b1, 1'b0);   // w_ready 1,0,0,1 stalls
    upd_test();               // matrix 2 becomes old+1
    err_test();               // mat_sel==3
    rst_test();               // reset after three writes
    fwd_run(2, 1'b0, 1'b0);   // clean restart from base 16
    fwd_run(0, 1'b0, 1'b1);   // run pulse during RUN is ignored

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
